// File: rtl/btn_debounce.sv
// Multi-channel push-button conditioner: 2-flop synchroniser, stability counter, press/release pulses.
// Optional auto-repeat of press pulses while held, enabled by defining BTN_DEBOUNCE_AUTOREPEAT_EN.
module btn_debounce #(
  parameter int N_BTN         = 4,
  parameter int CNT_W         = 16,
  parameter int STABLE_CYCLES = 50000,
  parameter int REPEAT_DELAY  = 5000000,
  parameter int REPEAT_PERIOD = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  // Reject configurations that would make a counter compare unreachable.
  if (STABLE_CYCLES < 1 || STABLE_CYCLES > (1 << CNT_W) ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("btn_debounce: illegal STABLE_CYCLES/REPEAT_DELAY/REPEAT_PERIOD");
  end

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
  localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
`endif

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_ch
      logic             r_s1;
      logic             r_s2;
      logic             r_level;
      logic             r_press;
      logic             r_release;
      logic [CNT_W-1:0] r_cnt;
      logic             w_flip;

      assign w_flip = (r_s2 != r_level) && (r_cnt == CNT_LAST);

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
      logic [RPT_W-1:0] r_rpt_cnt;
      logic             r_rpt_phase;
      logic             w_rpt_hit;

      // Phase 0 waits out the first-repeat delay, phase 1 runs the repeat period.
      assign w_rpt_hit = (r_rpt_cnt == (r_rpt_phase ? RPT_PERIOD_LAST : RPT_DELAY_LAST));
`endif

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_s1        <= 1'b0;
          r_s2        <= 1'b0;
          r_level     <= 1'b0;
          r_press     <= 1'b0;
          r_release   <= 1'b0;
          r_cnt       <= '0;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
          r_rpt_cnt   <= '0;
          r_rpt_phase <= 1'b0;
`endif
        end else begin
          r_s1      <= btn_raw[gi];
          r_s2      <= r_s1;
          r_press   <= 1'b0;
          r_release <= 1'b0;
          if (r_s2 == r_level) begin
            r_cnt <= '0;
          end else if (w_flip) begin
            r_level   <= r_s2;
            r_cnt     <= '0;
            r_press   <= r_s2;
            r_release <= ~r_s2;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
          // The flip edge restarts timing so the first repeat is measured from the press pulse.
          if (!r_level || w_flip) begin
            r_rpt_cnt   <= '0;
            r_rpt_phase <= 1'b0;
          end else if (w_rpt_hit) begin
            r_rpt_cnt   <= '0;
            r_rpt_phase <= 1'b1;
            r_press     <= 1'b1;
          end else begin
            r_rpt_cnt <= r_rpt_cnt + 1'b1;
          end
`endif
        end
      end

      assign btn_level[gi]   = r_level;
      assign btn_press[gi]   = r_press;
      assign btn_release[gi] = r_release;
    end
  endgenerate

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Multi-channel push-button conditioner. It is the receiving end of the raw, bouncing button inputs that arrive on ui_in[3:0].
- Each channel is synchronised into the clk domain, then filtered with a per-channel stability counter.
- Outputs per channel: a clean level, a one-cycle press pulse and a one-cycle release pulse.
- The pulses feed the segment-pattern/changing logic in the 7-segment design.

Parameters:
- N_BTN, 4: number of independent button channels.
- CNT_W, 16: width of each channel's stability counter.
- STABLE_CYCLES, 50000: consecutive clk cycles a synchronised input must differ from the current level before the level flips. 50000 is 5 ms at 10 MHz. Legal range is 1 to 2^CNT_W.
- REPEAT_DELAY, 5000000: auto-repeat first-repeat delay in cycles. Used only with the optional feature.
- REPEAT_PERIOD, 1000000: auto-repeat interval in cycles. Used only with the optional feature.

Ports:
- clk  in  1  system clock (10 MHz nominal)
- rst_n  in  1  reset, asynchronous, active-low
- btn_raw  in  N_BTN  raw asynchronous button inputs, active-high
- btn_level  out  N_BTN  debounced level per channel
- btn_press  out  N_BTN  one-cycle pulse on a debounced 0->1 transition
- btn_release  out  N_BTN  one-cycle pulse on a debounced 1->0 transition

Behaviour:
- Clocking and reset:
  - One clock, clk. All state is on the rising edge of clk.
  - Reset is asynchronous and active-low on rst_n.
  - While rst_n=0, everything is cleared immediately, independent of clk: synchroniser flops, counters, btn_level, btn_press and btn_release all go to 0. Optional repeat counters are also cleared.
  - Reset asserted mid-count discards the partial count. After release, each channel restarts from level 0 / count 0.
- Synchroniser: a 2-flop chain per channel, btn_raw -> s1 -> s2. Only s2 is used downstream.
- Per-channel filter, evaluated every clk edge with cnt of width CNT_W:
  - If s2 == level: cnt <= 0.
  - Else if cnt == STABLE_CYCLES-1: level <= s2 and cnt <= 0. Set press <= s2 and release <= ~s2.
  - Else: cnt <= cnt+1.
  - press and release are 0 on every edge not listed above, so each pulse lasts exactly one cycle.
- Latency:
  - Define edge 0 as the first edge at which btn_raw shows the new value.
  - btn_level changes at edge STABLE_CYCLES+1.
  - The press or release pulse is high for exactly the cycle following that edge, coincident with the new level.
- Glitch rejection: any s2 sample that equals the current level resets cnt. Bounces shorter than STABLE_CYCLES consecutive synchronised cycles therefore never change the level and produce no pulse.
- Invariants:
  - btn_press[i] and btn_release[i] are never high in the same cycle.
  - Channels are fully independent. Simultaneous transitions on several channels yield simultaneous pulses.
- Counter width: cnt never exceeds STABLE_CYCLES-1, so there is no wrap-around.
  - STABLE_CYCLES=1: the level follows s2 with one extra register stage.

Optional Feature:
- Macro: BTN_DEBOUNCE_AUTOREPEAT_EN.
- When defined, each channel adds a repeat counter (width $clog2 of the larger of REPEAT_DELAY and REPEAT_PERIOD).
  - While btn_level[i] is 1, an extra one-cycle btn_press[i] pulse is issued REPEAT_DELAY cycles after the original press pulse.
  - After that, a further pulse is issued every REPEAT_PERIOD cycles.
  - The repeat counter clears when the level drops to 0, and on reset.
  - btn_release behaviour is unchanged.
- When not defined, there is no repeat logic and btn_press pulses only on the debounced rising transition.

Test Plan:
Bench parameters: STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, N_BTN=4.
1. Reset: hold rst_n=0 with btn_raw=4'hF for 10 cycles -> btn_level, btn_press and btn_release all 4'h0 throughout. Assert rst_n=0 asynchronously between edges -> outputs clear without waiting for an edge.
2. Clean press: btn_raw[0] steps 0->1 at edge 0 and holds -> btn_level[0]=1 after edge 5. btn_press=4'b0001 for exactly one cycle, btn_release stays 0. With the macro, extra btn_press[0] pulses are 10 cycles later and then every 3 cycles.
3. Bounce: btn_raw[1] toggles every 2 cycles for 8 toggles, then holds 1 -> no pulse during the bouncing, then exactly one btn_press[1] pulse, 5 edges after the final rising edge.
4. Release: channel 2 stable high, then btn_raw[2] 1->0 -> btn_level[2]=0 after edge 5 and exactly one btn_release=4'b0100 pulse. A 3-cycle low glitch instead produces no change.
5. Simultaneous: btn_raw 4'b0000->4'b1010 on one edge -> btn_press=4'b1010 in a single cycle. Then btn_raw=4'b0000 -> btn_release=4'b1010 in a single cycle.
6. Reset mid-count: btn_raw[3]=1 for 3 cycles, then pulse rst_n low, then hold btn_raw[3]=1 -> btn_level[3] rises 5 edges after reset release, never earlier.
